// File: rtl/bidir_count_n_if.sv
// bidir_count_n_if: control, data and status bundle for bidir_count_n
interface bidir_count_n_if #(parameter int WIDTH = 8);
   logic             en;
   logic             load;
   logic             up_down;
   logic             sat;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic             clr_flags;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
   logic             cfg_err;
   logic             ovf;
   logic             unf;
   modport master (
      output en, load, up_down, sat, d, lo, hi, clr_flags,
      input  q, tc, wrap, cfg_err, ovf, unf
   );
   modport slave (
      input  en, load, up_down, sat, d, lo, hi, clr_flags,
      output q, tc, wrap, cfg_err, ovf, unf
   );
endinterface

// File: rtl/bidir_count_n.sv
// bidir_count_n: up/down counter bounded by [lo,hi] with saturate or wrap at the limits.
// Define BIDIR_COUNT_N_FLAGS_EN to build in the sticky ovf/unf flags.
module bidir_count_n #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          reset,
   bidir_count_n_if.slave bus
);
   logic [WIDTH-1:0] q_r, q_nxt;
   logic             wrap_r, wrap_nxt, at_lim, counting;
   always_comb begin
      counting = bus.en && !bus.load && !bus.cfg_err;
      at_lim   = bus.up_down ? (q_r >= bus.hi) : (q_r <= bus.lo);
      wrap_nxt = counting && !bus.sat && at_lim;
      q_nxt    = bus.load ? bus.d :
                 !counting ? q_r :
                 !at_lim ? (bus.up_down ? q_r + WIDTH'(1) : q_r - WIDTH'(1)) :
                 (bus.sat == bus.up_down) ? bus.hi : bus.lo;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_r    <= '0;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         wrap_r <= wrap_nxt;
      end
   end
   assign bus.q       = q_r;
   assign bus.wrap    = wrap_r;
   assign bus.cfg_err = bus.lo > bus.hi;
   assign bus.tc      = (bus.up_down && q_r >= bus.hi) || (!bus.up_down && q_r <= bus.lo);
`ifdef BIDIR_COUNT_N_FLAGS_EN
   logic ovf_r, unf_r;
   // a wrap in the same cycle as clr_flags leaves the flag set
   always_ff @(posedge clk) begin
      if (!reset) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         ovf_r <= (wrap_nxt && bus.up_down) || (ovf_r && !bus.clr_flags);
         unf_r <= (wrap_nxt && !bus.up_down) || (unf_r && !bus.clr_flags);
      end
   end
   assign bus.ovf = ovf_r;
   assign bus.unf = unf_r;
`else
   assign bus.ovf = 1'b0;
   assign bus.unf = 1'b0;
`endif
endmodule

// File: tb/tb_bidir_count_n.sv
// tb_bidir_count_n: directed checks of bidir_count_n at WIDTH=8
module tb_bidir_count_n;
`ifdef BIDIR_COUNT_N_FLAGS_EN
   localparam logic F = 1'b1;
`else
   localparam logic F = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   bidir_count_n_if #(.WIDTH(8)) bus ();
   bidir_count_n #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set(input logic l, input logic e, input logic [7:0] dv);
      bus.load = l;
      bus.en   = e;
      bus.d    = dv;
   endtask
   initial begin
      reset = 1'b0;
      bus.en = 1'b1; bus.load = 1'b1; bus.d = 8'h55; bus.up_down = 1'b1; bus.sat = 1'b0;
      bus.lo = 8'd0; bus.hi = 8'hFF; bus.clr_flags = 1'b0;
      #2;
      tick();
      chk("rst_q", bus.q, 0);
      chk("rst_wrap", bus.wrap, 0);
      chk("rst_ovf", bus.ovf, 0);
      chk("rst_unf", bus.unf, 0);
      reset = 1'b1;
      bus.lo = 8'd3; bus.hi = 8'd6;
      set(1, 0, 8'd5);
      tick();
      chk("ld5_q", bus.q, 5);
      chk("ld5_tc", bus.tc, 0);
      chk("cfg_ok", bus.cfg_err, 0);
      set(0, 1, 8'd0);
      tick();
      chk("up_q6", bus.q, 6);
      chk("up_q6_wrap", bus.wrap, 0);
      chk("up_q6_tc", bus.tc, 1);
      tick();
      chk("up_wrap_q3", bus.q, 3);
      chk("up_wrap_pulse", bus.wrap, 1);
      chk("up_wrap_tc", bus.tc, 0);
      chk("up_wrap_ovf", bus.ovf, F);
      tick();
      chk("up_q4", bus.q, 4);
      chk("up_q4_wrap", bus.wrap, 0);
      chk("up_q4_tc", bus.tc, 0);
      bus.sat = 1'b1; bus.up_down = 1'b0;
      set(1, 0, 8'd4);
      tick();
      chk("dsat_ld_tc", bus.tc, 0);
      set(0, 1, 8'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("dsat_q", bus.q, 3);
         chk("dsat_wrap", bus.wrap, 0);
         chk("dsat_tc", bus.tc, 1);
      end
      chk("dsat_unf", bus.unf, 0);
      set(1, 1, 8'hAA);
      tick();
      chk("load_wins", bus.q, 8'hAA);
      set(0, 1, 8'd0);
      tick();
      chk("out_down_dec", bus.q, 8'hA9);
      bus.up_down = 1'b1;
      tick();
      chk("out_up_clamp", bus.q, 6);
      chk("out_up_clamp_wrap", bus.wrap, 0);
      bus.lo = 8'd10; bus.hi = 8'd5; bus.sat = 1'b0;
      set(1, 0, 8'd7);
      #1;
      chk("cfg_err", bus.cfg_err, 1);
      tick();
      chk("cfg_ld7", bus.q, 7);
      set(0, 1, 8'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("cfg_hold", bus.q, 7);
         chk("cfg_wrap", bus.wrap, 0);
      end
      set(1, 1, 8'd2);
      tick();
      chk("cfg_ld2", bus.q, 2);
      bus.lo = 8'd3; bus.hi = 8'd6; bus.up_down = 1'b0;
      set(1, 0, 8'd3);
      tick();
      set(0, 1, 8'd0);
      tick();
      chk("dn_wrap_q", bus.q, 6);
      chk("dn_wrap_pulse", bus.wrap, 1);
      chk("dn_wrap_unf", bus.unf, F);
      set(0, 0, 8'd0);
      tick();
      chk("hold_q", bus.q, 6);
      chk("hold_wrap", bus.wrap, 0);
      bus.lo = 8'd0; bus.hi = 8'hFF; bus.up_down = 1'b1;
      set(1, 0, 8'hFF);
      tick();
      chk("ff_tc", bus.tc, 1);
      set(0, 1, 8'd0);
      tick();
      chk("ff_wrap_q", bus.q, 0);
      chk("ff_wrap_pulse", bus.wrap, 1);
      chk("ff_ovf", bus.ovf, F);
      set(0, 0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("ovf_held", bus.ovf, F);
         chk("ovf_wrap_low", bus.wrap, 0);
      end
      bus.clr_flags = 1'b1;
      tick();
      chk("clr_ovf", bus.ovf, 0);
      chk("clr_unf", bus.unf, 0);
      set(1, 0, 8'hFF);
      tick();
      set(0, 1, 8'd0);
      tick();
      chk("clr_and_wrap_ovf", bus.ovf, F);
      bus.clr_flags = 1'b0;
      bus.up_down = 1'b0;
      tick();
      chk("plain_dn_wrap", bus.q, 8'hFF);
      chk("plain_dn_unf", bus.unf, F);
      bus.up_down = 1'b1;
      tick();
      chk("plain_up_wrap", bus.q, 0);
      tick();
      chk("plain_up", bus.q, 1);
      reset = 1'b0;
      tick();
      chk("midrst_q", bus.q, 0);
      chk("midrst_ovf", bus.ovf, 0);
      reset = 1'b1;
      tick();
      chk("resume_q", bus.q, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bidir_count_n.md
BIDIR_COUNT_N -- requirements
Module: bidir_count_n

Interface
REQ-001 Parameter WIDTH, default 8, counter/data width in bits (SHALL be >= 2).
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-004 en  input  1  count enable.
REQ-005 load  input  1  parallel load strobe.
REQ-006 up_down  input  1  direction: 1 = up, 0 = down.
REQ-007 sat  input  1  limit mode: 1 = saturate at limit, 0 = wrap to opposite limit.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 lo  input  WIDTH  lower count limit, unsigned.
REQ-010 hi  input  WIDTH  upper count limit, unsigned.
REQ-011 clr_flags  input  1  clears sticky ovf/unf.
REQ-012 q  output  WIDTH  registered count value.
REQ-013 tc  output  1  combinational terminal count: (up_down & q>=hi) | (~up_down & q<=lo).
REQ-014 wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap transition.
REQ-015 cfg_err  output  1  combinational, high when lo > hi.
REQ-016 ovf  output  1  sticky up-wrap flag (see Configuration).
REQ-017 unf  output  1  sticky down-wrap flag (see Configuration).

Function
REQ-018 Priority per edge SHALL be: reset > load > en count > hold.
REQ-019 load=1 SHALL set q <= d regardless of en, up_down, sat, limits or cfg_err; wrap <= 0.
REQ-020 Up count (en=1, load=0, up_down=1): q<hi -> q+1; q>=hi & sat=0 -> q<=lo, wrap<=1; q>=hi & sat=1 -> q<=hi.
REQ-021 Down count (en=1, load=0, up_down=0): q>lo -> q-1; q<=lo & sat=0 -> q<=hi, wrap<=1; q<=lo & sat=1 -> q<=lo.
REQ-022 A value loaded outside [lo,hi] SHALL be brought to the limit by the rules above on the next count (clamp or wrap); no other correction.
REQ-023 cfg_err=1 SHALL suppress counting: q holds, wrap<=0; load still applies.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH; with lo=0, hi=2^WIDTH-1 the block SHALL behave as a plain WIDTH-bit wrapping up/down counter.
REQ-025 wrap SHALL be 0 in every cycle not immediately following a wrap transition.
REQ-026 en=0 & load=0 SHALL hold q; wrap<=0.
REQ-027 Changing up_down, sat, lo or hi SHALL take effect on the next edge; no pipelining of controls.

Reset
REQ-028 reset=0 at a rising edge SHALL force q=0, wrap=0, ovf=0, unf=0, overriding load and en.
REQ-029 Reset mid-count SHALL discard in-progress state; counting resumes from 0 on the first edge with reset=1.
REQ-030 No asynchronous path from reset to any output; tc and cfg_err remain combinational from q/lo/hi/up_down.

Configuration
REQ-031 Macro BIDIR_COUNT_N_FLAGS_EN SHALL compile the sticky flags in or out.
REQ-032 Defined: ovf<=1 on every up-wrap, unf<=1 on every down-wrap; flags hold until clr_flags=1 or reset; a wrap and clr_flags in the same cycle SHALL leave the flag set.
REQ-033 Undefined: ovf and unf ports SHALL remain present, tied to constant 0; clr_flags ignored; no flag registers.

Verification (WIDTH=8)
REQ-034 reset=0 with load=1, d=8'h55, en=1 for one edge -> q=0, wrap=0, ovf=0, unf=0.
REQ-035 lo=3, hi=6, sat=0, up_down=1: load d=5 then en=1 three edges -> q=6,3,4; wrap=1 only in cycle q=3; tc=1 only while q=6.
REQ-036 lo=3, hi=6, sat=1, up_down=0, load d=4, en=1 four edges -> q=3,3,3,3; tc=1 from q=3; wrap never 1.
REQ-037 en=1, load=1, d=8'hAA same edge -> q=8'hAA (load wins, no count).
REQ-038 lo=10, hi=5 -> cfg_err=1; en=1 for four edges from q=7 -> q stays 7, wrap=0; load d=2 -> q=2.
REQ-039 Macro defined, lo=0, hi=8'hFF, sat=0, up from q=8'hFF -> q=0, wrap=1, ovf=1 held 5 cycles until clr_flags -> ovf=0; macro undefined -> ovf=0 throughout.
